// File: rtl/i2c_color_target.sv
// i2c_color_target: I2C target model of the colour sensor.
// SCL/SDA are oversampled on clk_in, START/STOP are decoded from the synchronised
// lines, and a single FSM handles address match, ACKs, the register pointer, write
// strobes and read-data shifting. All outputs are registered.
`timescale 1ns/1ps

module i2c_color_target #(
  parameter logic [6:0] TGT_ADDR = 7'h29,
  parameter int         SYNC_STG = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        i2c_scl,
  input  logic        i2c_sda_in,
  output logic        sda_oe,
  input  logic [15:0] clr_data,
  input  logic [15:0] red_data,
  input  logic [15:0] grn_data,
  input  logic [15:0] blu_data,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR  = 4'd1,
    ST_ACK_A = 4'd2,
    ST_PTR   = 4'd3,
    ST_ACK_P = 4'd4,
    ST_WDATA = 4'd5,
    ST_ACK_W = 4'd6,
    ST_RDATA = 4'd7,
    ST_MACK  = 4'd8,
    ST_WAIT  = 4'd9
  } state_t;

  // Read map over the sensor snapshot; unmapped pointers return zero.
  function automatic logic [7:0] read_map(input logic [7:0] ptr, input logic [63:0] snap);
    logic [7:0] val;
    case (ptr)
      8'h00:   val = snap[7:0];
      8'h01:   val = snap[15:8];
      8'h02:   val = snap[23:16];
      8'h03:   val = snap[31:24];
      8'h04:   val = snap[39:32];
      8'h05:   val = snap[47:40];
      8'h06:   val = snap[55:48];
      8'h07:   val = snap[63:56];
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  logic [SYNC_STG-1:0] scl_sync_q;
  logic [SYNC_STG-1:0] sda_sync_q;
  logic                scl_prev_q;
  logic                sda_prev_q;

  logic                scl_s;
  logic                sda_s;
  logic                scl_rise_s;
  logic                scl_fall_s;
  logic                start_s;
  logic                stop_s;

  state_t              state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic                rw_q;
  logic                mack_ack_q;
  logic [7:0]          ptr_q;
  logic [63:0]         snap_q;
  logic                sda_oe_q;
  logic                busy_q;
  logic                wr_en_q;
  logic [7:0]          wr_addr_q;
  logic [7:0]          wr_data_q;

  logic [7:0]          rx_byte_s;
  logic [7:0]          rd_byte_s;

  // Bring the bus lines into the clk_in domain; idle bus level is high.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STG-2:0], i2c_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STG-2:0], i2c_sda_in};
    end
  end

  // Previous synchronised levels for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STG-1];
  assign sda_s      = sda_sync_q[SYNC_STG-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  // Only an SDA edge seen while the current SCL sample is high counts, so START and
  // STOP are mutually exclusive and a simultaneous SCL/SDA toggle resolves on SCL=1.
  assign start_s    = scl_s & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & ~sda_prev_q & sda_s;

  assign rx_byte_s  = {shift_q[6:0], sda_s};
  assign rd_byte_s  = read_map(ptr_q, snap_q);

  // Protocol FSM: bus conditions first, then per-state SCL edge handling.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      mack_ack_q <= 1'b0;
      ptr_q      <= 8'h00;
      snap_q     <= 64'h0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      if (stop_s) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_s) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_q   <= rx_byte_s;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rx_byte_s[7:1] == TGT_ADDR) begin
                  state_q <= ST_ACK_A;
                  busy_q  <= 1'b1;
                  rw_q    <= rx_byte_s[0];
                end else begin
                  state_q <= ST_IDLE;
                end
              end
            end
          end
          ST_ACK_A: begin
            // The only rise seen in this state is the ACK clock itself.
            if (scl_rise_s) begin
              snap_q <= {blu_data, grn_data, red_data, clr_data};
            end
            if (scl_fall_s) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if (rw_q) begin
                shift_q   <= {rd_byte_s[6:0], 1'b0};
                sda_oe_q  <= ~rd_byte_s[7];
                bit_cnt_q <= 3'd0;
                state_q   <= ST_RDATA;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (scl_rise_s) begin
              shift_q   <= rx_byte_s;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q   <= rx_byte_s;
                state_q <= ST_ACK_P;
              end
            end
          end
          ST_ACK_P, ST_ACK_W: begin
            // First fall pulls SDA low, second fall (end of the ACK clock) releases it.
            if (scl_fall_s) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (scl_rise_s) begin
              shift_q   <= rx_byte_s;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= rx_byte_s;
                ptr_q     <= ptr_q + 8'd1;
                state_q   <= ST_ACK_W;
              end
            end
          end
          ST_RDATA: begin
            // shift_q holds the bits still to be sent, next one in bit 7.
            if (scl_fall_s) begin
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q   <= 1'b0;
                ptr_q      <= ptr_q + 8'd1;
                mack_ack_q <= 1'b0;
                state_q    <= ST_MACK;
              end else begin
                sda_oe_q  <= ~shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          ST_MACK: begin
            if (scl_rise_s) begin
              if (sda_s) begin
                state_q <= ST_WAIT;
              end else begin
                mack_ack_q <= 1'b1;
              end
            end else if (scl_fall_s && mack_ack_q) begin
              shift_q   <= {rd_byte_s[6:0], 1'b0};
              sda_oe_q  <= ~rd_byte_s[7];
              bit_cnt_q <= 3'd0;
              state_q   <= ST_RDATA;
            end else begin
              mack_ack_q <= mack_ack_q;
            end
          end
          ST_WAIT: begin
            sda_oe_q <= 1'b0;
          end
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_color_target.sv
// tb_i2c_color_target: bus-controller model driving the colour-sensor target with
// a table of read-map vectors plus directed write/read/abort/reset/snapshot sequences.
`timescale 1ns/1ps

module tb_i2c_color_target;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        scl_m;
  logic        sda_m;
  logic        sda_bus;
  logic        sda_oe;
  logic [15:0] clr_data;
  logic [15:0] red_data;
  logic [15:0] grn_data;
  logic [15:0] blu_data;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Write-strobe and level monitors.
  logic [7:0] stb_addr [0:63];
  logic [7:0] stb_data [0:63];
  int         stb_cnt  = 0;
  int         oe_cnt   = 0;
  int         busy_cnt = 0;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] exp_byte;
  } rd_vec_t;

  rd_vec_t vecs [0:9];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk_in = ~clk_in;

  i2c_color_target #(.TGT_ADDR(7'h29), .SYNC_STG(2)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .i2c_scl     (scl_m),
    .i2c_sda_in  (sda_bus),
    .sda_oe      (sda_oe),
    .clr_data    (clr_data),
    .red_data    (red_data),
    .grn_data    (grn_data),
    .blu_data    (blu_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy)
  );

  always @(negedge clk_in) begin
    if (reg_wr_en) begin
      if (stb_cnt < 64) begin
        stb_addr[stb_cnt] <= reg_wr_addr;
        stb_data[stb_cnt] <= reg_wr_data;
      end
      stb_cnt <= stb_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One SCL clock: set SDA in the low phase, sample the wire mid-high.
  task automatic put_bit(input logic b, output logic w);
    sda_m = b;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(4);
    w = sda_bus;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic w;
    for (int i = 7; i >= 0; i--) put_bit(b[i], w);
    put_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic w;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, w);
      b[i] = w;
    end
    put_bit(mack, w);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b0;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic read_at(input logic [7:0] ptr, output logic [7:0] b);
    logic a;
    bus_start();
    send_byte(8'h52, a);
    check("rd_wr_addr_ack", 16'(a), 16'h0000);
    send_byte(ptr, a);
    check("rd_ptr_ack", 16'(a), 16'h0000);
    bus_start();
    send_byte(8'h53, a);
    check("rd_rd_addr_ack", 16'(a), 16'h0000);
    recv_byte(1'b1, b);
    bus_stop();
  endtask

  initial begin
    logic       a;
    logic       w;
    logic [7:0] b;
    logic [7:0] v;
    int         base;
    int         oe_base;
    int         busy_base;

    vecs[0] = '{ptr: 8'h00, exp_byte: 8'h34};
    vecs[1] = '{ptr: 8'h01, exp_byte: 8'h12};
    vecs[2] = '{ptr: 8'h02, exp_byte: 8'hEF};
    vecs[3] = '{ptr: 8'h03, exp_byte: 8'hBE};
    vecs[4] = '{ptr: 8'h04, exp_byte: 8'h6B};
    vecs[5] = '{ptr: 8'h05, exp_byte: 8'h5A};
    vecs[6] = '{ptr: 8'h06, exp_byte: 8'hDE};
    vecs[7] = '{ptr: 8'h07, exp_byte: 8'hC0};
    vecs[8] = '{ptr: 8'h08, exp_byte: 8'h00};
    vecs[9] = '{ptr: 8'hFF, exp_byte: 8'h00};

    clr_data = 16'h1234;
    red_data = 16'hBEEF;
    grn_data = 16'h5A6B;
    blu_data = 16'hC0DE;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rst_n    = 1'b0;
    wait_clk(5);
    check("rst_sda_oe", 16'(sda_oe), 16'h0000);
    check("rst_wr_en", 16'(reg_wr_en), 16'h0000);
    check("rst_wr_addr", 16'(reg_wr_addr), 16'h0000);
    check("rst_wr_data", 16'(reg_wr_data), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    rst_n = 1'b1;
    wait_clk(5);

    // Read map, one byte per vector.
    for (int i = 0; i < 10; i++) begin
      read_at(vecs[i].ptr, b);
      check($sformatf("rdmap_%0d", i), 16'(b), 16'(vecs[i].exp_byte));
    end

    // T1: single write.
    base = stb_cnt;
    bus_start();
    send_byte(8'h52, a);
    check("t1_addr_ack", 16'(a), 16'h0000);
    send_byte(8'h03, a);
    check("t1_ptr_ack", 16'(a), 16'h0000);
    send_byte(8'hA5, a);
    check("t1_data_ack", 16'(a), 16'h0000);
    check("t1_busy_before_stop", 16'(busy), 16'h0001);
    bus_stop();
    check("t1_busy_after_stop", 16'(busy), 16'h0000);
    check("t1_strobe_cycles", 16'(stb_cnt - base), 16'h0001);
    check("t1_strobe_addr", 16'(stb_addr[base]), 16'h0003);
    check("t1_strobe_data", 16'(stb_data[base]), 16'h00A5);

    // T2: pointer write, repeated START, 3-byte read.
    bus_start();
    send_byte(8'h52, a);
    send_byte(8'h00, a);
    bus_start();
    send_byte(8'h53, a);
    check("t2_rd_addr_ack", 16'(a), 16'h0000);
    recv_byte(1'b0, b);
    check("t2_byte0", 16'(b), 16'h0034);
    recv_byte(1'b0, b);
    check("t2_byte1", 16'(b), 16'h0012);
    recv_byte(1'b1, b);
    check("t2_byte2", 16'(b), 16'h00EF);
    oe_base = oe_cnt;
    put_bit(1'b1, w);
    check("t2_released_bit0", 16'(w), 16'h0001);
    put_bit(1'b1, w);
    check("t2_released_bit1", 16'(w), 16'h0001);
    bus_stop();
    check("t2_no_drive_after_nack", 16'(oe_cnt - oe_base), 16'h0000);

    // T3: address mismatch.
    base      = stb_cnt;
    oe_base   = oe_cnt;
    busy_base = busy_cnt;
    bus_start();
    send_byte(8'h60, a);
    check("t3_addr_nack", 16'(a), 16'h0001);
    send_byte(8'h00, a);
    check("t3_data_nack", 16'(a), 16'h0001);
    bus_stop();
    check("t3_oe_never", 16'(oe_cnt - oe_base), 16'h0000);
    check("t3_busy_never", 16'(busy_cnt - busy_base), 16'h0000);
    check("t3_no_strobe", 16'(stb_cnt - base), 16'h0000);

    // T4: pointer wrap.
    base = stb_cnt;
    bus_start();
    send_byte(8'h52, a);
    send_byte(8'hFF, a);
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    bus_stop();
    check("t4_strobe_cycles", 16'(stb_cnt - base), 16'h0002);
    check("t4_strobe0_addr", 16'(stb_addr[base]), 16'h00FF);
    check("t4_strobe0_data", 16'(stb_data[base]), 16'h0011);
    check("t4_strobe1_addr", 16'(stb_addr[base + 1]), 16'h0000);
    check("t4_strobe1_data", 16'(stb_data[base + 1]), 16'h0022);

    // T5a: STOP after 4 data bits.
    base = stb_cnt;
    bus_start();
    send_byte(8'h52, a);
    send_byte(8'h10, a);
    put_bit(1'b1, w);
    put_bit(1'b0, w);
    put_bit(1'b1, w);
    put_bit(1'b1, w);
    bus_stop();
    check("t5_busy_after_abort", 16'(busy), 16'h0000);
    check("t5_no_strobe", 16'(stb_cnt - base), 16'h0000);

    // T5b: reset pulse while the address ACK is being driven.
    v = 8'h52;
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(v[i], w);
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(2);
    check("t5_ack_driven", 16'(sda_oe), 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_sda_oe", 16'(sda_oe), 16'h0000);
    check("t5_rst_busy", 16'(busy), 16'h0000);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    scl_m = 1'b0;
    wait_clk(4);
    bus_stop();
    // Pointer was 0x10 before reset; reset brings it back to 0x00.
    bus_start();
    send_byte(8'h53, a);
    check("t5_post_rst_ack", 16'(a), 16'h0000);
    recv_byte(1'b1, b);
    bus_stop();
    check("t5_post_rst_ptr0", 16'(b), 16'h0034);

    // T6: sensor change after address ACK does not affect returned bytes.
    red_data = 16'hBEEF;
    bus_start();
    send_byte(8'h52, a);
    send_byte(8'h02, a);
    bus_start();
    send_byte(8'h53, a);
    red_data = 16'h1357;
    recv_byte(1'b0, b);
    check("t6_byte0", 16'(b), 16'h00EF);
    red_data = 16'h2468;
    recv_byte(1'b1, b);
    check("t6_byte1", 16'(b), 16'h00BE);
    bus_stop();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
